// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between client blocks and the
// shared-ALU arbiter.
//   i_req_valid  N        per-requester request valid
//   o_req_ready  N        one-hot grant (combinational)
//   i_req_a/b    N*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//   i_req_op     N*3      opcodes, requester i at [i*3 +: 3]
//   o_rsp_valid  N        one-hot response strobe
//   o_rsp_result WIDTH    result, 0 when no response
//   o_rsp_zero/cf 1       flags, 0 when no response
//   o_pending    N        requester has an operation in flight
// master = client side, slave = arbiter side.
`ifndef WORD
`define WORD 8
`endif

interface alu_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = `WORD
);
  logic [N-1:0]       i_req_valid;
  logic [N-1:0]       o_req_ready;
  logic [N*WIDTH-1:0] i_req_a;
  logic [N*WIDTH-1:0] i_req_b;
  logic [N*3-1:0]     i_req_op;
  logic [N-1:0]       o_rsp_valid;
  logic [WIDTH-1:0]   o_rsp_result;
  logic               o_rsp_zero;
  logic               o_rsp_cf;
  logic [N-1:0]       o_pending;

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_op,
    input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_zero, o_rsp_cf,
           o_pending
  );

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_op,
    output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_zero, o_rsp_cf,
           o_pending
  );
endinterface

// File: rtl/alu_arbiter.sv
// pipeline_alu: two-stage ALU. Stage 1 registers operands, stage 2 registers
// the computed result and flags, so a result appears two cycles after issue.
//   i_clk, i_rst       clock, async active-high reset
//   i_valid, i_a, i_b, i_op   issue side
//   o_valid, o_result, o_zero, o_cf   result side
// Opcodes: 0 ADD, 1 SUB (cf = borrow), 2 AND, 3 OR, 4 XOR,
//          5 SHL by 1 (cf = msb out), 6 SHR by 1 (cf = lsb out), 7 pass B.
//
// alu_arbiter: round-robin arbiter sharing one pipeline_alu between N
// requesters, one operation in flight per requester, tagged responses.
//   i_clk, i_rst   clock, async active-high reset
//   bus            alu_arbiter_if slave modport (request/response bundle)
`ifndef WORD
`define WORD 8
`endif

module pipeline_alu #(
  parameter int WIDTH = `WORD
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_cf
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;

  logic             v1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [2:0]       op1;
  logic [WIDTH:0]   ext;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      op1 <= '0;
    end else begin
      v1 <= i_valid;
      if (i_valid) begin
        a1  <= i_a;
        b1  <= i_b;
        op1 <= i_op;
      end
    end
  end

  // ext[WIDTH] is the carry/borrow/shifted-out bit.
  always_comb begin
    ext = '0;
    case (op1)
      OP_ADD:  ext = {1'b0, a1} + {1'b0, b1};
      OP_SUB:  ext = {1'b0, a1} - {1'b0, b1};
      OP_AND:  ext = {1'b0, a1 & b1};
      OP_OR:   ext = {1'b0, a1 | b1};
      OP_XOR:  ext = {1'b0, a1 ^ b1};
      OP_SHL:  ext = {a1, 1'b0};
      OP_SHR:  ext = {a1[0], 1'b0, a1[WIDTH-1:1]};
      default: ext = {1'b0, b1};
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_zero   <= 1'b0;
      o_cf     <= 1'b0;
    end else begin
      o_valid  <= v1;
      o_result <= ext[WIDTH-1:0];
      o_zero   <= (ext[WIDTH-1:0] == '0);
      o_cf     <= ext[WIDTH];
    end
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH = `WORD,
  parameter int N     = 4,
  parameter int IDW   = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  alu_arbiter_if.slave bus
);
  localparam logic [IDW:0]   N_EXT = (IDW+1)'(N);
  localparam logic [IDW-1:0] LAST  = IDW'(N-1);
  localparam logic [N-1:0]   ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt;
  logic [IDW:0]     cand;
  logic             found;
  logic             fire;
  logic [N-1:0]     pending;
  logic [N-1:0]     eligible;
  logic [N-1:0]     ready;
  logic [N-1:0]     set_mask;
  logic [N-1:0]     rsp_oh;
  logic [IDW-1:0]   tag1;
  logic [IDW-1:0]   tag2;
  logic             tv1;
  logic             tv2;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic             alu_valid;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_cf;

  assign eligible = bus.i_req_valid & ~pending;

  // Rotating search starting at ptr; the sum is kept one bit wider so the
  // wrap works for non-power-of-two N.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!found && eligible[cand[IDW-1:0]]) begin
        found = 1'b1;
        gnt   = cand[IDW-1:0];
      end
    end
  end

  assign ready    = found ? (ONE_N << gnt) : '0;
  assign fire     = |(bus.i_req_valid & ready);
  assign set_mask = fire ? (ONE_N << gnt) : '0;
  assign rsp_oh   = tv2 ? (ONE_N << tag2) : '0;

  assign alu_a  = bus.i_req_a[gnt*WIDTH +: WIDTH];
  assign alu_b  = bus.i_req_b[gnt*WIDTH +: WIDTH];
  assign alu_op = bus.i_req_op[gnt*3 +: 3];

  pipeline_alu #(.WIDTH(WIDTH)) u_alu (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (fire),
    .i_a      (alu_a),
    .i_b      (alu_b),
    .i_op     (alu_op),
    .o_valid  (alu_valid),
    .o_result (alu_result),
    .o_zero   (alu_zero),
    .o_cf     (alu_cf)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr     <= '0;
      pending <= '0;
      tag1    <= '0;
      tag2    <= '0;
      tv1     <= 1'b0;
      tv2     <= 1'b0;
    end else begin
      if (fire) ptr <= (gnt == LAST) ? '0 : gnt + 1'b1;
      // A pending requester is never granted, so set and clear never
      // target the same bit.
      pending <= (pending & ~rsp_oh) | set_mask;
      tag1    <= gnt;
      tv1     <= fire;
      tag2    <= tag1;
      tv2     <= tv1;
    end
  end

  assign bus.o_req_ready  = ready;
  assign bus.o_rsp_valid  = rsp_oh;
  assign bus.o_rsp_result = tv2 ? alu_result : '0;
  assign bus.o_rsp_zero   = tv2 & alu_zero;
  assign bus.o_rsp_cf     = tv2 & alu_cf;
  assign bus.o_pending    = pending;

  a_tag_aligned: assert property (@(posedge i_clk) disable iff (i_rst)
    tv2 == alu_valid);
  a_grant_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(ready));
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one pipeline_alu instance between N requesters using round-robin arbitration.
- Each requester may have at most one operation in flight.
- The block tags every issued operation, carries the tag through the ALU's 2-stage pipeline, and routes the result back as a one-hot response strobe.
- It sits between the client blocks (sequencers, DMA-style engines) and the shared ALU, and it instantiates that ALU internally.

Parameters:
- WIDTH, `WORD, operand/result width; passed to pipeline_alu.
- N, 4, number of requesters (2..8).
- IDW, $clog2(N), width of the tag and of the round-robin pointer.

Ports:
- i_clk  in  1  single clock, all state on posedge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  N  per-requester request valid.
- o_req_ready  out  N  per-requester grant; at most one bit set, combinational.
- i_req_a  in  N*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- i_req_b  in  N*WIDTH  operand B, same packing.
- i_req_op  in  N*3  ALU opcode, requester i at [i*3 +: 3].
- o_rsp_valid  out  N  one-hot response strobe, one cycle wide.
- o_rsp_result  out  WIDTH  ALU result; forced to 0 when o_rsp_valid==0.
- o_rsp_zero  out  1  ALU zero flag; forced to 0 when no response.
- o_rsp_cf  out  1  ALU carry flag; forced to 0 when no response.
- o_pending  out  N  requester i has an operation in flight.

Behaviour:
- Eligibility:
  - eligible = i_req_valid & ~pending.
  - Grant goes to the first eligible index searching from ptr upward, modulo N.
  - o_req_ready is one-hot of the grant, or 0 if nothing is eligible.
  - o_req_ready is purely combinational from i_req_valid, pending and ptr.
- Fire:
  - Fire = i_req_valid[g] & o_req_ready[g].
  - The granted requester's operands/opcode are muxed onto the ALU inputs with ALU i_valid = fire.
  - When there is no fire, operands are don't-care and ALU i_valid = 0.
- On the posedge after a fire:
  - ptr <= (g+1) mod N.
  - pending[g] <= 1.
  - tag1 <= g, tv1 <= 1. Otherwise tv1 <= 0 and ptr holds.
- Tag pipeline:
  - tag2 <= tag1, tv2 <= tv1 on every posedge.
  - tv2 is aligned with ALU o_valid. A mismatch is a design error; add an assertion.
- Response:
  - o_rsp_valid = tv2 ? onehot(tag2) : 0.
  - Result and flags are passed from the ALU, gated by tv2.
  - No backpressure: a requester must accept its response in that cycle.
- Latency:
  - Request fires in cycle k; o_rsp_valid is high in cycle k+2.
  - pending clears on the posedge ending cycle k+2.
  - The requester is eligible again in cycle k+3.
- Throughput:
  - Aggregate rate is one issue per cycle.
  - Per requester, at most one issue per 3 cycles.
- Simultaneous events:
  - Set and clear of the same pending bit cannot coincide, because a pending requester is never granted.
  - Clear of requester i and set of requester j (j≠i) in the same edge both take effect.
- i_req_valid dropped before a grant: no issue, no state change.
- Requester contract: operands must be held stable while valid and not yet ready.
- Reset (asynchronous, may hit mid-operation):
  - ptr=0, pending=0, tv1=tv2=0, ALU valid pipeline cleared.
  - All in-flight operations are discarded and no response is produced for them.
  - Outputs during and after reset: o_req_ready follows the combinational grant; o_rsp_valid=0, o_rsp_result=0, o_rsp_zero=0, o_rsp_cf=0, o_pending=0.
- Widths:
  - ptr/tag arithmetic wraps modulo N, including non-power-of-2 N: ptr==N-1 wraps to 0.
  - No operand/result width change; the ALU defines the arithmetic.

Test Plan:
- Single requester 0: a=8'h03, b=8'h04, OP_ADD, valid in cycle 0. Expect ready[0]=1 in cycle 0, o_rsp_valid=4'b0001 with result 8'h07, zero=0, cf=0 in cycle 2. Expect pending[0]=1 in cycles 1-2, 0 in cycle 3.
- All 4 requesters hold valid continuously from cycle 0. Expect grants 0,1,2,3 in cycles 0-3 and responses in cycles 2-5 in the same order. Requester 0 is eligible again at cycle 3 but the pointer is at 3, so it is granted at cycle 4.
- Requester 2: a=8'hFF, b=8'h01, OP_ADD. Expect result 8'h00, zero=1, cf=1, o_rsp_valid=4'b0100. All response fields are 0 in the cycles before and after.
- Pointer wrap: ptr=3, requesters 0 and 3 valid. Grant goes to 3, then 0 on the next eligible cycle; ptr wraps 3 → 0 → 1.
- Reset mid-flight: issue from requester 1, assert i_rst asynchronously (between edges) in cycle 1 for 2 cycles. Expect o_rsp_valid to stay 0 throughout, pending=0 immediately, and requester 1 granted in the first cycle after reset if valid.
- Back-to-back same requester: requester 0 holds valid. Expect issues in cycles 0, 3, 6 and o_req_ready[0]=0 in cycles 1-2 and 4-5.
